// File: rtl/cphase_applier.sv
// Controlled-phase gate engine: scans a 2^QUBITS complex state vector in external RAM and
// multiplies every amplitude whose control and target bits are both set by a latched phase.
module cphase_applier #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned QUBITS = 4,
    parameter int unsigned QSEL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [QSEL_W-1:0] ctrl_q,
    input  logic [QSEL_W-1:0] tgt_q,
    input  logic [DATA_W-1:0] phase_real,
    input  logic [DATA_W-1:0] phase_img,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              mem_rd_en,
    output logic [QUBITS-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata_real,
    input  logic [DATA_W-1:0] mem_rdata_img,
    output logic              mem_we,
    output logic [QUBITS-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata_real,
    output logic [DATA_W-1:0] mem_wdata_img,
    output logic [DATA_W-1:0] mul_a_real,
    output logic [DATA_W-1:0] mul_a_img,
    output logic [DATA_W-1:0] mul_b_real,
    output logic [DATA_W-1:0] mul_b_img,
    input  logic [DATA_W-1:0] mul_s_real,
    input  logic [DATA_W-1:0] mul_s_img,
    input  logic              mul_overflow
);

    localparam logic [QUBITS-1:0] LastIdx = '1;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StLoad,
        StCapt,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [QUBITS-1:0] idx_q, idx_d;
    logic [QSEL_W-1:0] ctrl_sel_q, ctrl_sel_d;
    logic [QSEL_W-1:0] tgt_sel_q, tgt_sel_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic [DATA_W-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
    logic [DATA_W-1:0] w_re_q, w_re_d, w_im_q, w_im_d;
    logic              touch;

    // A select value with no matching bit position (>= QUBITS) yields 0, so nothing is touched.
    function automatic logic sel_bit(input logic [QUBITS-1:0] v, input logic [QSEL_W-1:0] sel);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < QUBITS; i++) begin
            if (sel == QSEL_W'(i)) begin
                hit = v[i];
            end
        end
        return hit;
    endfunction

    assign touch = sel_bit(idx_q, ctrl_sel_q) & sel_bit(idx_q, tgt_sel_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ctrl_sel_d = ctrl_sel_q;
        tgt_sel_d  = tgt_sel_q;
        overflow_d = overflow_q;
        a_re_d     = a_re_q;
        a_im_d     = a_im_q;
        b_re_d     = b_re_q;
        b_im_d     = b_im_q;
        w_re_d     = w_re_q;
        w_im_d     = w_im_q;
        mem_rd_en  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    ctrl_sel_d = ctrl_q;
                    tgt_sel_d  = tgt_q;
                    b_re_d     = phase_real;
                    b_im_d     = phase_img;
                    overflow_d = 1'b0;
                    idx_d      = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (touch) begin
                    mem_rd_en = 1'b1;
                    state_d   = StLoad;
                end else if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StLoad: begin
                a_re_d  = mem_rdata_real;
                a_im_d  = mem_rdata_img;
                state_d = StCapt;
            end
            StCapt: begin
                w_re_d     = mul_s_real;
                w_im_d     = mul_s_img;
                overflow_d = overflow_q | mul_overflow;
                state_d    = StWrite;
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StScan;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ctrl_sel_q <= '0;
            tgt_sel_q  <= '0;
            overflow_q <= 1'b0;
            a_re_q     <= '0;
            a_im_q     <= '0;
            b_re_q     <= '0;
            b_im_q     <= '0;
            w_re_q     <= '0;
            w_im_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ctrl_sel_q <= ctrl_sel_d;
            tgt_sel_q  <= tgt_sel_d;
            overflow_q <= overflow_d;
            a_re_q     <= a_re_d;
            a_im_q     <= a_im_d;
            b_re_q     <= b_re_d;
            b_im_q     <= b_im_d;
            w_re_q     <= w_re_d;
            w_im_q     <= w_im_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them immediately.
    assign busy           = (state_q == StScan) || (state_q == StLoad) ||
                            (state_q == StCapt) || (state_q == StWrite);
    assign done           = (state_q == StDone);
    assign mem_we         = (state_q == StWrite);
    assign overflow       = overflow_q;
    assign mem_raddr      = idx_q;
    assign mem_waddr      = idx_q;
    assign mem_wdata_real = w_re_q;
    assign mem_wdata_img  = w_im_q;
    assign mul_a_real     = a_re_q;
    assign mul_a_img      = a_im_q;
    assign mul_b_real     = b_re_q;
    assign mul_b_img      = b_im_q;

endmodule

// File: tb/tb_cphase_applier.sv
// Self-checking bench for cphase_applier: RAM and multiplier models plus a per-run reference
// of the expected final state vector, write sequence, busy length and overflow.
module tb_cphase_applier;

    localparam int DW = 32;
    localparam int QB = 3;
    localparam int QS = 3;
    localparam int N  = 8;
    localparam longint One = 65536;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [QS-1:0] ctrl_q, tgt_q;
    logic [DW-1:0] phase_real, phase_img;
    logic          busy, done, overflow;
    logic          mem_rd_en, mem_we;
    logic [QB-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_rdata_real, mem_rdata_img, mem_wdata_real, mem_wdata_img;
    logic [DW-1:0] mul_a_real, mul_a_img, mul_b_real, mul_b_img, mul_s_real, mul_s_img;
    logic          mul_overflow, mdl_ovf, force_ovf, arm_ovf, rd3_d1, rd3_d2;

    always #5 clk = ~clk;

    cphase_applier #(.DATA_W(DW), .QUBITS(QB), .QSEL_W(QS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl_q(ctrl_q), .tgt_q(tgt_q),
        .phase_real(phase_real), .phase_img(phase_img), .busy(busy), .done(done),
        .overflow(overflow), .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
        .mem_rdata_real(mem_rdata_real), .mem_rdata_img(mem_rdata_img), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata_real(mem_wdata_real), .mem_wdata_img(mem_wdata_img),
        .mul_a_real(mul_a_real), .mul_a_img(mul_a_img), .mul_b_real(mul_b_real),
        .mul_b_img(mul_b_img), .mul_s_real(mul_s_real), .mul_s_img(mul_s_img),
        .mul_overflow(mul_overflow)
    );

    function automatic longint sm2i(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    // Returns {overflow, sign, magnitude}.
    function automatic logic [32:0] i2sm(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        return {m >= 64'sd2147483648, (v < 0) && (m != 0), m[30:0]};
    endfunction

    // Q15.16 sign-magnitude complex product, truncating toward zero; returns {ovf, re, im}.
    function automatic logic [64:0] cmul(input logic [31:0] ar, ai, br, bi);
        logic [32:0] r, m;
        r = i2sm((sm2i(ar) * sm2i(br) - sm2i(ai) * sm2i(bi)) / One);
        m = i2sm((sm2i(ar) * sm2i(bi) + sm2i(ai) * sm2i(br)) / One);
        return {r[32] | m[32], r[31:0], m[31:0]};
    endfunction

    always_comb begin
        {mdl_ovf, mul_s_real, mul_s_img} = cmul(mul_a_real, mul_a_img, mul_b_real, mul_b_img);
    end
    assign force_ovf    = rd3_d2;
    assign mul_overflow = mdl_ovf | force_ovf;

    // RAM model and activity monitors.
    logic [31:0] ram_re[N], ram_im[N];
    int busy_cnt, done_cnt, rd_cnt, clash_cnt;
    int wr_a[$];
    logic [31:0] wr_r[$], wr_i[$];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata_real <= ram_re[mem_raddr];
            mem_rdata_img  <= ram_im[mem_raddr];
        end
        if (mem_we) begin
            ram_re[mem_waddr] <= mem_wdata_real;
            ram_im[mem_waddr] <= mem_wdata_img;
            wr_a.push_back(int'(mem_waddr));
            wr_r.push_back(mem_wdata_real);
            wr_i.push_back(mem_wdata_img);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_rd_en && mem_we) clash_cnt <= clash_cnt + 1;
        // Forces mul_overflow during the CAPT cycle two cycles after the read of index 3.
        rd3_d1 <= arm_ovf && mem_rd_en && (mem_raddr == 3'd3);
        rd3_d2 <= rd3_d1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        busy_cnt  <= 0;
        done_cnt  <= 0;
        rd_cnt    <= 0;
        clash_cnt <= 0;
        wr_a.delete();
        wr_r.delete();
        wr_i.delete();
        @(negedge clk);
    endtask

    task automatic preload(input bit rnd);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rnd) begin
                ram_re[i] <= {1'($urandom_range(0, 1)), 31'($urandom_range(0, 1 << 20))};
                ram_im[i] <= {1'($urandom_range(0, 1)), 31'($urandom_range(0, 1 << 20))};
            end else begin
                ram_re[i] <= 32'(i + 1);
                ram_im[i] <= 32'd0;
            end
        end
    endtask

    task automatic run(input int ctrl, input int tgt, input logic [31:0] pr, input logic [31:0] pi,
                       input bit disturb, input bit forced, input string name);
        logic [31:0] er[N], ei[N];
        int ea[$];
        logic [31:0] eqr[$], eqi[$];
        logic [64:0] p;
        int  ebusy, k;
        bit  eovf;
        clear_mon();
        ebusy = 0;
        eovf  = forced;
        for (int i = 0; i < N; i++) begin
            er[i] = ram_re[i];
            ei[i] = ram_im[i];
        end
        for (int i = 0; i < N; i++) begin
            if (ctrl < QB && tgt < QB && ((i >> ctrl) & 1) == 1 && ((i >> tgt) & 1) == 1) begin
                p = cmul(er[i], ei[i], pr, pi);
                eovf  = eovf | p[64];
                er[i] = p[63:32];
                ei[i] = p[31:0];
                ea.push_back(i);
                eqr.push_back(er[i]);
                eqi.push_back(ei[i]);
                ebusy += 4;
            end else begin
                ebusy += 1;
            end
        end
        ctrl_q     = QS'(ctrl);
        tgt_q      = QS'(tgt);
        phase_real = pr;
        phase_img  = pi;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " ovf_clear"}, 64'(overflow), 64'd0);
        chk({name, " busy_up"}, 64'(busy), 64'd1);
        if (disturb) begin
            repeat (2) @(negedge clk);
            start      = 1'b1;
            ctrl_q     = 3'd0;
            tgt_q      = 3'd0;
            phase_real = ~pr;
            phase_img  = 32'h0000_4000;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({name, " done_seen"}, 64'(done_cnt > 0), 64'd1);
        chk({name, " ovf_at_done"}, 64'(overflow), 64'(eovf));
        repeat (3) @(negedge clk);
        chk({name, " done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, " busy_cyc"}, 64'(busy_cnt), 64'(ebusy));
        chk({name, " rd_cnt"}, 64'(rd_cnt), 64'(ea.size()));
        chk({name, " clash"}, 64'(clash_cnt), 64'd0);
        chk({name, " wr_cnt"}, 64'(wr_a.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
            chk($sformatf("%s wr%0d_addr", name, i), 64'(wr_a[i]), 64'(ea[i]));
            chk($sformatf("%s wr%0d_re", name, i), 64'(wr_r[i]), 64'(eqr[i]));
            chk($sformatf("%s wr%0d_im", name, i), 64'(wr_i[i]), 64'(eqi[i]));
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s ram%0d", name, i), {ram_re[i], ram_im[i]}, {er[i], ei[i]});
        end
        chk({name, " ovf_hold"}, 64'(overflow), 64'(eovf));
    endtask

    initial begin
        int k;
        logic [31:0] r3, r7;
        rst_n      = 1'b1;
        start      = 1'b0;
        ctrl_q     = '0;
        tgt_q      = '0;
        phase_real = '0;
        phase_img  = '0;
        arm_ovf    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst mem_we", 64'(mem_we), 64'd0);
        chk("rst rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst ovf", 64'(overflow), 64'd0);
        chk("rst mul_b", {mul_b_real, mul_b_img}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        preload(1'b0);
        run(0, 1, 32'd0, 32'(One), 1'b0, 1'b0, "c0t1");
        preload(1'b0);
        run(2, 2, 32'd0, 32'(One), 1'b0, 1'b0, "c2t2");
        preload(1'b1);
        run(5, 1, 32'h8000_8000, 32'h0000_b505, 1'b0, 1'b0, "csel5");

        preload(1'b1);
        arm_ovf = 1'b1;
        run(0, 1, 32'h0000_b505, 32'h8000_b505, 1'b0, 1'b1, "force_ovf");
        arm_ovf = 1'b0;

        preload(1'b1);
        run(0, 2, 32'h0000_ddb4, 32'h0000_8000, 1'b1, 1'b0, "midrun");

        for (int t = 0; t < 6; t++) begin
            preload(1'b1);
            run($urandom_range(0, 3), $urandom_range(0, 3),
                {1'($urandom_range(0, 1)), 31'($urandom_range(0, 65536))},
                {1'($urandom_range(0, 1)), 31'($urandom_range(0, 65536))},
                1'b0, 1'b0, $sformatf("rand%0d", t));
        end

        // Asynchronous reset during the write of index 3.
        preload(1'b0);
        clear_mon();
        r3 = ram_re[3];
        r7 = ram_re[7];
        ctrl_q     = 3'd0;
        tgt_q      = 3'd1;
        phase_real = 32'd0;
        phase_img  = 32'(One);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(mem_we && mem_waddr == 3'd3) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("arst reached_wr3", 64'(mem_we && mem_waddr == 3'd3), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst mem_we", 64'(mem_we), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst waddr", 64'(mem_waddr), 64'd0);
        chk("arst wdata", {mem_wdata_real, mem_wdata_img}, 64'd0);
        chk("arst mul_a", {mul_a_real, mul_a_img}, 64'd0);
        chk("arst mul_b", {mul_b_real, mul_b_img}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst wr_cnt", 64'(wr_a.size()), 64'd0);
        chk("arst ram3", 64'(ram_re[3]), 64'(r3));
        chk("arst ram7", 64'(ram_re[7]), 64'(r7));
        chk("arst done", 64'(done_cnt), 64'd0);
        run(0, 1, 32'd0, 32'(One), 1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cphase_applier.md
Name: cphase_applier

Overview:
- Sequential stage directly upstream of the signed complex multiplier, and the consumer of its result.
- Applies a controlled-phase gate diag(1,…,e^{iθ}) to a 2^QUBITS-entry complex state vector held in an external synchronous RAM.
- Scans every basis index. For each index whose control and target bits are both 1, it reads the amplitude, presents amplitude × phase to the multiplier, captures the product, and writes it back in place.
- All data is sign-magnitude fixed point, DATA_W bits per component: MSB is the sign, negation is an MSB flip.

Parameters:
- DATA_W, 32, width of each real/imag component (sign-magnitude).
- QUBITS, 4, number of qubits; state vector depth is 2^QUBITS, address width is QUBITS.
- QSEL_W, 3, width of the qubit-select inputs; must satisfy 2^QSEL_W ≥ QUBITS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- ctrl_q  in  QSEL_W  control qubit index; latched on start.
- tgt_q  in  QSEL_W  target qubit index; latched on start.
- phase_real  in  DATA_W  cos θ; latched on start.
- phase_img  in  DATA_W  sin θ; latched on start.
- busy  out  1  high while scanning.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky OR of mul_overflow over the current run.
- mem_rd_en  out  1  RAM read strobe.
- mem_raddr  out  QUBITS  RAM read address.
- mem_rdata_real  in  DATA_W  RAM read data, real part; valid the cycle after mem_rd_en.
- mem_rdata_img  in  DATA_W  RAM read data, imag part; same timing.
- mem_we  out  1  RAM write strobe.
- mem_waddr  out  QUBITS  RAM write address.
- mem_wdata_real  out  DATA_W  RAM write data, real part.
- mem_wdata_img  out  DATA_W  RAM write data, imag part.
- mul_a_real, mul_a_img  out  DATA_W each  registered amplitude operand to the multiplier.
- mul_b_real, mul_b_img  out  DATA_W each  registered phase operand to the multiplier.
- mul_s_real, mul_s_img  in  DATA_W each  combinational product from the multiplier.
- mul_overflow  in  1  multiplier overflow flag.

Behaviour:
- Reset (async, rst_n=0): every output and internal register goes to 0 immediately. State returns to IDLE, mem_we drops at once, and no further write occurs. Amplitudes already written stay modified; no rollback.
- FSM states: IDLE → SCAN → LOAD → CAPT → WRITE → SCAN …; the last index leads to DONE → IDLE.
- IDLE:
  - busy=0.
  - start=1 latches ctrl_q, tgt_q, phase_*, loads mul_b_* with the phase, clears overflow and idx.
  - Next state is SCAN.
- SCAN, busy=1, evaluates idx:
  - touch = idx[ctrl_q] & idx[tgt_q]. If ctrl_q==tgt_q, this is a single-qubit phase on that bit.
  - A qubit select ≥ QUBITS never matches, so all indices are skipped and done is still produced.
  - Skip: idx++ in the same cycle, with no memory access. Costs 1 cycle.
  - Touch: mem_rd_en=1, mem_raddr=idx, next state LOAD.
- LOAD: register mem_rdata_* into mul_a_*.
- CAPT:
  - Register mul_s_* into the write-data registers.
  - overflow |= mul_overflow.
- WRITE:
  - mem_we=1, mem_waddr=idx, mem_wdata=captured product.
  - Then idx++ and return to SCAN, or go to DONE if idx was 2^QUBITS−1.
  - A touched index therefore costs 4 cycles: SCAN, LOAD, CAPT, WRITE.
- Last index: when idx=2^QUBITS−1 and it is skipped, SCAN goes directly to DONE. idx never wraps into a second pass.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - overflow holds its value until the next accepted start.
- Strobe rules:
  - mem_rd_en and mem_we are never high in the same cycle.
  - mem_we is high only in WRITE.
  - mem_rd_en is high only in a touching SCAN cycle.
- start handling: ignored in all states other than IDLE, including DONE. start held high in IDLE immediately re-launches a run the cycle after DONE.
- Latching: inputs changing mid-run have no effect; only the values latched at start are used.
- Latency: busy cycles = skipped + 4·touched. done asserts on the cycle after the last busy cycle.

Test Plan:
- QUBITS=3, ctrl_q=0, tgt_q=1, RAM[i]=(i+1, 0), phase=(0, +1.0):
  - Writes occur only at addresses 3 and 7, with data equal to the multiplier model output.
  - busy is high for exactly 14 cycles, done pulses once, and all other RAM entries are unchanged.
- ctrl_q=tgt_q=2, QUBITS=3: touched indices are 4,5,6,7, giving four writes in ascending order and busy=4+16=20 cycles.
- ctrl_q=5 with QUBITS=3: no reads and no writes, busy=8 cycles, then done.
- Force mul_overflow=1 during CAPT of index 3 only:
  - overflow rises after that CAPT and stays high through done.
  - The next start clears it to 0.
- Pulse start plus changed phase mid-run: no effect on the current run; products still use the original phase, and only one done is produced.
- Drop rst_n asynchronously during the WRITE of index 3:
  - All outputs are 0 immediately and RAM[7] is never written.
  - After release, a fresh start completes a normal run.
